// File: rtl/lifo_stack.sv
// Purpose: register-based LIFO operand stack with a combinational top-of-stack peek.
// Latency: push/pop take effect on the clock edge; POP_DAT shows the new top in the following cycle.
// Backpressure: none; push while FULL and pop while EMPTY are dropped (optionally flagged on ERR).
//
// Ports:
//   CLK       rising-edge clock for all state
//   RST       synchronous active-high reset; clears the count, overrides strobes
//   PUSH_STB  push request, one push per cycle sampled high
//   PUSH_DAT  word to push, sampled with PUSH_STB
//   POP_STB   pop request, one pop per cycle sampled high
//   POP_DAT   current top of stack, 0 when empty
//   EMPTY     count == 0
//   FULL      count == DEPTH
//   COUNT     number of valid entries
//   ERR       (only when LIFO_STACK_ERR_EN is defined) sticky overflow/underflow flag
//
// Build option: define LIFO_STACK_ERR_EN to add the ERR output.

module lifo_stack #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 20,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             PUSH_STB,
   input  logic [WIDTH-1:0] PUSH_DAT,
   input  logic             POP_STB,
   output logic [WIDTH-1:0] POP_DAT,
   output logic             EMPTY,
   output logic             FULL,
   output logic [CW-1:0]    COUNT
`ifdef LIFO_STACK_ERR_EN
   ,
   output logic             ERR
`endif
);

   // Address width for the storage array; CW may be one bit wider than needed.
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    cnt;

   logic             is_empty;
   logic             is_full;
   logic [CW-1:0]    top_idx;
   logic             wr_en;
   logic [CW-1:0]    wr_idx;
   logic             cnt_inc;
   logic             cnt_dec;

   assign is_empty = (cnt == '0);
   assign is_full  = (cnt == CW'(DEPTH));
   assign top_idx  = cnt - CW'(1);

   // Operation decode.
   //  - push+pop on a non-empty stack rewrites the top in place (allowed when full)
   //  - push+pop on an empty stack degenerates into a plain push into slot 0
   //  - lone push while full and lone pop while empty are dropped
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = cnt;
      cnt_inc = 1'b0;
      cnt_dec = 1'b0;
      if (!RST) begin
         if (PUSH_STB && POP_STB) begin
            wr_en = 1'b1;
            if (is_empty) begin
               wr_idx  = '0;
               cnt_inc = 1'b1;
            end else begin
               wr_idx  = top_idx;
            end
         end else if (PUSH_STB) begin
            if (!is_full) begin
               wr_en   = 1'b1;
               wr_idx  = cnt;
               cnt_inc = 1'b1;
            end
         end else if (POP_STB) begin
            cnt_dec = !is_empty;
         end
      end
   end

   // Count register; the decode guards keep it inside 0..DEPTH.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt <= '0;
      end else if (cnt_inc) begin
         cnt <= cnt + CW'(1);
      end else if (cnt_dec) begin
         cnt <= cnt - CW'(1);
      end
   end

   // Storage is never cleared: entries at or above cnt are unobservable.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem[wr_idx[AW-1:0]] <= PUSH_DAT;
      end
   end

   assign POP_DAT = is_empty ? '0 : mem[top_idx[AW-1:0]];
   assign EMPTY   = is_empty;
   assign FULL    = is_full;
   assign COUNT   = cnt;

`ifdef LIFO_STACK_ERR_EN
   logic err;

   // Sticky until reset: records any dropped overflow or underflow attempt.
   always_ff @(posedge CLK) begin
      if (RST) begin
         err <= 1'b0;
      end else if ((PUSH_STB && !POP_STB && is_full) ||
                   (POP_STB && !PUSH_STB && is_empty)) begin
         err <= 1'b1;
      end
   end

   assign ERR = err;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Purpose: randomized and directed check of lifo_stack against a queue-based stack model.
// Latency: expectations are checked one cycle after the edge that produced them.
// Backpressure: not applicable; stimulus drives one operation per cycle.

module tb_lifo_stack;

   localparam int WIDTH = 32;
   localparam int DEPTH = 20;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             CLK;
   logic             RST;
   logic             PUSH_STB;
   logic [WIDTH-1:0] PUSH_DAT;
   logic             POP_STB;
   logic [WIDTH-1:0] POP_DAT;
   logic             EMPTY;
   logic             FULL;
   logic [CW-1:0]    COUNT;
`ifdef LIFO_STACK_ERR_EN
   logic             ERR;
`endif

   lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .PUSH_STB (PUSH_STB),
      .PUSH_DAT (PUSH_DAT),
      .POP_STB  (POP_STB),
      .POP_DAT  (POP_DAT),
      .EMPTY    (EMPTY),
      .FULL     (FULL),
      .COUNT    (COUNT)
`ifdef LIFO_STACK_ERR_EN
      ,
      .ERR      (ERR)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      int               cnt;
      logic [WIDTH-1:0] top;
      bit               err;
      string            tag;
   } exp_t;

   exp_t             exp_q[$];
   logic [WIDTH-1:0] model[$];
   bit               model_err;
   int               n_chk  = 0;
   int               n_fail = 0;

   function automatic void chk(string tag, string nm, logic [63:0] act, logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s/%s: got %0h required %0h", tag, nm, act, req);
      end
   endfunction

   // Reference behaviour: a plain queue used as a stack.
   task automatic op(input bit rst, input bit push, input bit pop,
                     input logic [WIDTH-1:0] d, input string tag);
      exp_t e;
      @(negedge CLK);
      RST      = rst;
      PUSH_STB = push;
      POP_STB  = pop;
      PUSH_DAT = d;
      if (rst) begin
         model.delete();
         model_err = 1'b0;
      end else if (push && pop) begin
         if (model.size() == 0) model.push_back(d);
         else                   model[model.size()-1] = d;
      end else if (push) begin
         if (model.size() < DEPTH) model.push_back(d);
         else                      model_err = 1'b1;
      end else if (pop) begin
         if (model.size() > 0) void'(model.pop_back());
         else                  model_err = 1'b1;
      end
      e.cnt = model.size();
      e.top = (model.size() == 0) ? '0 : model[model.size()-1];
      e.err = model_err;
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   // Monitor: compares the state produced by each edge against the queued expectation.
   always @(posedge CLK) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk(e.tag, "count",   64'(COUNT),   64'(e.cnt));
         chk(e.tag, "pop_dat", 64'(POP_DAT), 64'(e.top));
         chk(e.tag, "empty",   64'(EMPTY),   64'(e.cnt == 0));
         chk(e.tag, "full",    64'(FULL),    64'(e.cnt == DEPTH));
`ifdef LIFO_STACK_ERR_EN
         chk(e.tag, "err",     64'(ERR),     64'(e.err));
`endif
      end
   end

   initial begin
      RST = 1'b1; PUSH_STB = 1'b0; POP_STB = 1'b0; PUSH_DAT = '0;
      model_err = 1'b0;

      // Reset with a push strobe held: push must be discarded.
      op(1, 1, 0, 32'h55, "reset");
      op(1, 1, 0, 32'h55, "reset");

      // LIFO order.
      op(0, 1, 0, 3, "lifo_push");
      op(0, 1, 0, 4, "lifo_push");
      op(0, 1, 0, 7, "lifo_push");
      for (int i = 0; i < 3; i++) op(0, 0, 1, 0, "lifo_pop");

      // RPN sequence.
      op(0, 1, 0, 5,  "rpn");
      op(0, 1, 0, 6,  "rpn");
      op(0, 0, 1, 0,  "rpn");
      op(0, 0, 1, 0,  "rpn");
      op(0, 1, 0, 30, "rpn");

      // Fill, overflow attempt, replace while full.
      op(1, 0, 0, 0, "rst");
      for (int i = 1; i <= DEPTH; i++) op(0, 1, 0, i, "fill");
      op(0, 1, 0, 99,  "overflow");
      op(0, 0, 0, 0,   "overflow_hold");
      op(0, 1, 1, 123, "replace_full");
      op(0, 0, 1, 0,   "pop_after_full");

      // Underflow attempt; ERR stays set until reset.
      op(1, 0, 0, 0, "rst");
      op(0, 0, 1, 0, "underflow");
      op(0, 1, 0, 9, "err_sticky");
      op(0, 0, 0, 0, "err_sticky");
      op(1, 0, 1, 0, "err_clear");

      // Simultaneous push and pop.
      op(0, 1, 0, 8, "simul");
      op(0, 1, 1, 9, "simul_replace");
      op(1, 0, 0, 0, "rst");
      op(0, 1, 1, 2, "simul_empty");

      // Randomized phases alternating push-heavy and pop-heavy bias.
      for (int i = 0; i < 3000; i++) begin
         int  bias;
         bit  rst, push, pop;
         bias = ((i / 200) % 2 == 0) ? 70 : 30;
         rst  = ($urandom_range(0, 199) == 0);
         push = ($urandom_range(0, 99) < bias);
         pop  = ($urandom_range(0, 99) < (100 - bias));
         op(rst, push, pop, $urandom, "random");
      end

      @(negedge CLK);
      RST = 1'b0; PUSH_STB = 1'b0; POP_STB = 1'b0;
      repeat (3) @(negedge CLK);
      chk("end", "drain", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/lifo_stack.md
# lifo_stack

Parameterised last-in/first-out register stack (module `lifo_stack`) used as the operand store of the RPN calculator datapath. The top-of-stack word is presented continuously on `POP_DAT`. The controller samples `POP_DAT` and then strobes `POP_STB` to discard that word, or strobes `PUSH_STB` to store a new word. Single clock domain; no handshake back-pressure, with full/empty status exported.

## Interface
- `WIDTH`, default 32: data word width in bits (≥1).
- `DEPTH`, default 20: number of entries (≥2); `CW = $clog2(DEPTH+1)` is the count width.

- `CLK`  in  1: clock; all state updates on rising edge.
- `RST`  in  1: reset. Synchronous and active-high.
- `PUSH_STB`  in  1: push request. Each cycle sampled high is one push.
- `PUSH_DAT`  in  WIDTH: data to push, sampled with `PUSH_STB`.
- `POP_STB`  in  1: pop request. Each cycle sampled high is one pop.
- `POP_DAT`  out  WIDTH: current top of stack (combinational peek); 0 when empty.
- `EMPTY`  out  1: count == 0.
- `FULL`  out  1: count == DEPTH.
- `COUNT`  out  CW: number of valid entries.

## Operation
- Storage: `DEPTH`×`WIDTH` register array `mem`, plus count register `cnt`. The top entry is `mem[cnt-1]`.
- `POP_DAT = (cnt != 0) ? mem[cnt-1] : 0`. It is purely combinational from registers, so it is valid in the same cycle the controller samples it.
- Per rising edge, with RST low:
  - Push only, not FULL: `mem[cnt] <= PUSH_DAT`; `cnt <= cnt+1`.
  - Push only, FULL: ignored; no state change.
  - Pop only, not EMPTY: `cnt <= cnt-1`. The memory contents are left untouched.
  - Pop only, EMPTY: ignored; `cnt` stays 0.
  - Push and pop together, not EMPTY: replace top. `mem[cnt-1] <= PUSH_DAT`; `cnt` is unchanged. This applies even when FULL.
  - Push and pop together, EMPTY: treated as a push only (`mem[0] <= PUSH_DAT`, `cnt <= 1`).
  - Neither: hold.
- Strobes are level-qualified, not edge-detected. A strobe held N cycles performs N operations, and the controller is responsible for single-cycle pulses.
- No arithmetic on data. Count arithmetic is saturating by the guards above; it never wraps.

## Timing
- Reset: on a rising edge with RST high, `cnt <= 0`. `mem` is not cleared. After reset `EMPTY=1`, `FULL=0`, `COUNT=0`, `POP_DAT=0`. RST overrides any strobes in the same cycle.
- Reset mid-operation: any push or pop strobed in the reset cycle is discarded.
- Push latency: a word pushed at edge k appears on `POP_DAT` immediately after edge k, i.e. in cycle k+1.
- Pop latency: after a pop at edge k, `POP_DAT` shows the next-lower entry in cycle k+1.
- `EMPTY`, `FULL` and `COUNT` change only on clock edges and reflect `cnt` at all times.
- Throughput: one operation per cycle, sustained.

## Configuration
- `LIFO_STACK_ERR_EN` defined: adds output `ERR` (1 bit, in the port list after `COUNT`).
  - `ERR` is a sticky flag, set on the edge where a push-only is attempted while FULL or a pop-only is attempted while EMPTY.
  - `ERR` is cleared only by RST; its reset value is 0.
- `LIFO_STACK_ERR_EN` undefined: no `ERR` port. Overflow and underflow attempts are silently ignored as described above.

## Test plan
- Reset: assert RST for 2 cycles with `PUSH_STB=1` and `PUSH_DAT=0x55`. Required: `EMPTY=1`, `COUNT=0`, `POP_DAT=0` afterwards, and no push takes effect.
- LIFO order: push 3, 4, 7, one cycle each. Required: `POP_DAT=7`, `COUNT=3`. Then pop one cycle per step, checking `POP_DAT` before each pop: the sequence read is 7, 4, 3, then `POP_DAT=0` with `EMPTY=1`.
- RPN sequence: push 5, push 6, sample `POP_DAT`=6, pop, sample `POP_DAT`=5, pop, push 30. Required: `COUNT=1` and `POP_DAT=30`.
- Full: push 1..20 with `DEPTH=20`. Required: `FULL=1`, `POP_DAT=20`. Push 99: `COUNT` stays 20 and `POP_DAT=20`. With `LIFO_STACK_ERR_EN`, `ERR=1`.
- Empty: pop on an empty stack. Required: `COUNT=0`, `POP_DAT=0`. With `LIFO_STACK_ERR_EN`, `ERR=1` and it stays set until RST.
- Simultaneous: push 8, then assert push 9 together with pop for one cycle. Required: `COUNT=1`, `POP_DAT=9`. On an empty stack, push 2 together with pop gives `COUNT=1`, `POP_DAT=2`.
